// File: rtl/clock_tick_controller_pkg.sv
// Shared definitions for the clock tick controller: set-mode encoding and a
// counter sizing helper used by the prescaler, debouncers and repeat timer.
package clock_tick_controller_pkg;

    typedef enum logic [1:0] {
        MODE_RUN         = 2'd0,
        MODE_SET_HOURS   = 2'd1,
        MODE_SET_MINUTES = 2'd2,
        MODE_RESERVED    = 2'd3
    } mode_e;

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int counter_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/clock_tick_controller_button_debouncer.sv
// Raw button front end: two-flop synchroniser, stability-count debounce and a
// one-cycle press pulse on the debounced rising edge.
module clock_tick_controller_button_debouncer
    import clock_tick_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;
    logic          differ;
    logic          settle;

    assign differ = (sync2_reg != level_reg);
    assign settle = differ && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            press_reg <= settle && sync2_reg;
            // Any sample agreeing with the accepted level restarts the count.
            if (settle) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else if (differ) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/clock_tick_controller.sv
// Seconds prescaler, tick cascade and mode/adjust set FSM for the BCD time
// register. Define AUTO_REPEAT_EN to enable hold-to-repeat on the adjust button.
module clock_tick_controller
    import clock_tick_controller_pkg::*;
#(
    parameter int TICK_DIVIDER         = 50000000,
    parameter int DEBOUNCE_CYCLES      = 500000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_adjust,
    input  logic       wrap_hours,
    input  logic       wrap_minutes,
    input  logic       wrap_seconds,
    output logic       increment_hours,
    output logic       increment_minutes,
    output logic       increment_seconds,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int PW = counter_width(TICK_DIVIDER);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIVIDER - 1);
    localparam logic [PW-1:0] BLINK_HALF = PW'(TICK_DIVIDER / 2);

    mode_e         mode_reg, mode_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic          inc_h_reg, inc_h_next;
    logic          inc_m_reg, inc_m_next;
    logic          inc_s_reg, inc_s_next;
    logic          blink_reg, blink_next;
    logic          tick;
    logic          mode_press;
    logic          adj_press;
    logic          adj_fire;
    logic [1:0]    btn_vec, level_vec, press_vec;

    // Bit 0 is the mode button, bit 1 the adjust button.
    assign btn_vec = {btn_adjust, btn_mode};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        clock_tick_controller_button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk  (clk),
            .reset(reset),
            .btn  (btn_vec[gi]),
            .level(level_vec[gi]),
            .press(press_vec[gi])
        );
    end

    assign mode_press = press_vec[0];
    assign adj_press  = press_vec[1];
    assign tick       = (presc_reg == PRESC_LAST);

    // Hours wrap is handled inside the time register itself.
    logic unused_inputs;
    assign unused_inputs = ^{wrap_hours, level_vec[0]};

`ifdef AUTO_REPEAT_EN
    localparam int RW = counter_width((REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                      REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);

    logic [RW-1:0] rep_cnt_reg;
    logic          rep_armed_reg;
    logic          rep_periodic_reg;
    logic          rep_fire;
    logic          adj_level;

    assign adj_level = level_vec[1];
    assign rep_fire  = rep_armed_reg && adj_level &&
                       (rep_cnt_reg == (rep_periodic_reg ? PERIOD_LAST : DELAY_LAST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt_reg      <= '0;
            rep_armed_reg    <= 1'b0;
            rep_periodic_reg <= 1'b0;
        end else if (mode_press || !adj_level ||
                     mode_reg == MODE_RUN || mode_reg == MODE_RESERVED) begin
            rep_cnt_reg      <= '0;
            rep_armed_reg    <= 1'b0;
            rep_periodic_reg <= 1'b0;
        end else if (adj_press) begin
            rep_cnt_reg      <= '0;
            rep_armed_reg    <= 1'b1;
            rep_periodic_reg <= 1'b0;
        end else if (rep_armed_reg) begin
            if (rep_fire) begin
                rep_cnt_reg      <= '0;
                rep_periodic_reg <= 1'b1;
            end else begin
                rep_cnt_reg <= rep_cnt_reg + 1'b1;
            end
        end
    end

    assign adj_fire = adj_press || rep_fire;
`else
    // Without auto-repeat only the press edge matters; hold timing is irrelevant.
    localparam int unused_repeat_cfg = REPEAT_DELAY_CYCLES + REPEAT_PERIOD_CYCLES;
    logic unused_adj_level;
    assign unused_adj_level = level_vec[1];
    assign adj_fire = adj_press;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_reg  <= MODE_RUN;
            presc_reg <= '0;
            inc_h_reg <= 1'b0;
            inc_m_reg <= 1'b0;
            inc_s_reg <= 1'b0;
            blink_reg <= 1'b0;
        end else begin
            mode_reg  <= mode_next;
            presc_reg <= presc_next;
            inc_h_reg <= inc_h_next;
            inc_m_reg <= inc_m_next;
            inc_s_reg <= inc_s_next;
            blink_reg <= blink_next;
        end
    end

    always_comb begin
        mode_next  = mode_reg;
        presc_next = tick ? '0 : presc_reg + 1'b1;
        inc_s_next = (mode_reg == MODE_RUN) && tick;
        inc_m_next = inc_s_next && wrap_seconds;
        inc_h_next = inc_m_next && wrap_minutes;

        case (mode_reg)
            MODE_RUN:         if (mode_press) mode_next = MODE_SET_HOURS;
            MODE_SET_HOURS:   if (mode_press) mode_next = MODE_SET_MINUTES;
            MODE_SET_MINUTES: if (mode_press) mode_next = MODE_RUN;
            default:          mode_next = MODE_RUN;
        endcase

        // Re-entering RUN restarts the second so the first tick is a full period away.
        if (mode_reg == MODE_SET_MINUTES && mode_press) presc_next = '0;

        if (adj_fire && !mode_press) begin
            if (mode_reg == MODE_SET_HOURS)   inc_h_next = 1'b1;
            if (mode_reg == MODE_SET_MINUTES) inc_m_next = 1'b1;
        end

        blink_next = (mode_next != MODE_RUN) && (presc_next < BLINK_HALF);
    end

    assign increment_hours   = inc_h_reg;
    assign increment_minutes = inc_m_reg;
    assign increment_seconds = inc_s_reg;
    assign mode              = mode_reg;
    assign blink             = blink_reg;

endmodule
